// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// and helpers that slice the instruction byte into its fields.
package seq_pkg;

    // Opcode values carried in instr[7:5]
    localparam logic [2:0] OP_RALU = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_RSVD = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Field positions inside the instruction byte
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int J_IMM_W = 5;
    localparam int I_IMM_W = 2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    function automatic logic [2:0] get_op(input logic [7:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [J_IMM_W-1:0] get_j_imm(input logic [7:0] instr);
        return instr[J_IMM_W-1:0];
    endfunction

    function automatic logic [I_IMM_W-1:0] get_i_imm(input logic [7:0] instr);
        return instr[I_IMM_W-1:0];
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request waits without an ack and
// flags expiry once the count reaches TIMEOUT. An ack in the expiry cycle
// suppresses the flag, so a just-in-time response still completes.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] timer_q;
    logic [7:0] timer_d;

    // Next count: clear whenever the request is idle or answered, else advance up to the limit
    always_comb begin
        timer_d = timer_q;
        if (!req || ack) begin
            timer_d = 8'd0;
        end else if (timer_q != LIMIT) begin
            timer_d = timer_q + 8'd1;
        end
    end

    // Wait-cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= 8'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expired = req && !ack && (timer_q == LIMIT);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit core. Owns the
// PC and instruction register, fetches bytes over a req/ack port and emits
// registered one-cycle strobes for the ALU, data memory and register file.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [7:0]      imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      instr_q,
    output logic            alu_en,
    output logic            rf_we,
    output logic            instr_done,
    output logic            halted,
    output logic            fault
);

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      instr_d;
    logic            imem_req_q, imem_req_d;
    logic            dmem_req_q, dmem_req_d;
    logic            dmem_we_q, dmem_we_d;
    logic            alu_en_q, alu_en_d;
    logic            rf_we_q, rf_we_d;
    logic            done_q, done_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;

    logic [2:0]         op;
    logic [J_IMM_W-1:0] j_imm;
    logic [I_IMM_W-1:0] i_imm;
    logic [PC_W-1:0]    i_imm_sext;

    logic tmr_req, tmr_ack, tmr_expired;

    assign op         = get_op(instr_q);
    assign j_imm      = get_j_imm(instr_q);
    assign i_imm      = get_i_imm(instr_q);
    assign i_imm_sext = {{(PC_W-I_IMM_W){i_imm[I_IMM_W-1]}}, i_imm};

    // Only one of the two request ports is ever active, so a single timer watches whichever is live
    assign tmr_req = imem_req_q | dmem_req_q;
    assign tmr_ack = imem_req_q ? imem_ack : dmem_ack;

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (tmr_req),
        .ack    (tmr_ack),
        .expired(tmr_expired)
    );

    // Next-state, PC/IR update and next values of all registered strobes
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = 1'b0;
        alu_en_d   = 1'b0;
        rf_we_d    = 1'b0;
        done_d     = 1'b0;
        halted_d   = halted_q;
        fault_d    = fault_q;

        case (state_q)
            S_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_DECODE;
                    end else if (tmr_expired) begin
                        fault_d = 1'b1;
                        state_d = S_FAULT;
                    end else begin
                        imem_req_d = 1'b1;
                    end
                end else if (run) begin
                    imem_req_d = 1'b1;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_J: begin
                        pc_d    = {pc_q[PC_W-1:J_IMM_W], j_imm};
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_HALT: begin
                        halted_d = 1'b1;
                        done_d   = 1'b1;
                        state_d  = S_HALT;
                    end
                    OP_RSVD: begin
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        alu_en_d = 1'b1;
                        state_d  = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                case (op)
                    OP_BEQ: begin
                        if (zero_flag) begin
                            pc_d = pc_q + i_imm_sext;
                        end
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        dmem_req_d = 1'b1;
                        dmem_we_d  = (op == OP_SW);
                        state_d    = S_MEM;
                    end
                    default: begin
                        rf_we_d = 1'b1;
                        state_d = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_SW) begin
                        done_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        rf_we_d = 1'b1;
                        state_d = S_WB;
                    end
                end else if (tmr_expired) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = (op == OP_SW);
                end
            end
            S_WB: begin
                done_d  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State, PC/IR and output strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_RST;
            instr_q    <= 8'h00;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            done_q     <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            alu_en_q   <= alu_en_d;
            rf_we_q    <= rf_we_d;
            done_q     <= done_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign pc         = pc_q;
    assign imem_req   = imem_req_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign alu_en     = alu_en_q;
    assign rf_we      = rf_we_q;
    assign instr_done = done_q;
    assign halted     = halted_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of single-instruction records
// executed back to back from reset, followed by hand-written sequences for
// halt, timeout, run gating and reset in the middle of a data access.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       imem_req;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       zero_flag;
    logic [7:0] pc;
    logic [7:0] instr_q;
    logic       alu_en;
    logic       rf_we;
    logic       instr_done;
    logic       halted;
    logic       fault;

    int total = 0;
    int bad   = 0;

    instr_sequencer #(
        .PC_W    (8),
        .RESET_PC(0),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .zero_flag (zero_flag),
        .pc        (pc),
        .instr_q   (instr_q),
        .alu_en    (alu_en),
        .rf_we     (rf_we),
        .instr_done(instr_done),
        .halted    (halted),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        int         iwait;     // negedges between seeing imem_req and driving ack
        int         dwait;     // dmem_req cycles before ack
        logic       zero;
        logic       drop_run;  // pull run low when the data request appears
        logic [7:0] exp_pc;
        int         exp_lat;   // cycles from fetch ack to instr_done
        int         exp_alu;
        int         exp_rf;
        int         exp_dreq;
        int         exp_dwe;
    } rec_t;

    rec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs one instruction from fetch to retirement, acting as imem and dmem.
    task automatic run_instr(input rec_t r, input string tag);
        int lat, alu_c, rf_c, dreq_c, dwe_c, dcnt, guard;
        bit got;
        zero_flag = r.zero;
        run       = 1'b1;
        guard     = 0;
        while (imem_req !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (imem_req !== 1'b1) begin
            check({tag, "_fetch_req"}, int'(imem_req), 1);
            return;
        end
        repeat (r.iwait) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = r.instr;
        lat = 0; alu_c = 0; rf_c = 0; dreq_c = 0; dwe_c = 0; dcnt = 0; got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 8'h00;
            lat++;
            if (alu_en) alu_c++;
            if (rf_we)  rf_c++;
            if (dmem_req) begin
                if (r.drop_run) run = 1'b0;
                dreq_c++;
                if (dmem_we) dwe_c++;
                dmem_ack = (dcnt == r.dwait);
                dcnt++;
            end else begin
                dmem_ack = 1'b0;
            end
            if (instr_done) got = 1;
        end
        dmem_ack = 1'b0;
        check({tag, "_done_seen"}, int'(got), 1);
        check({tag, "_latency"},   lat,       r.exp_lat);
        check({tag, "_pc"},        int'(pc),  int'(r.exp_pc));
        check({tag, "_instr_q"},   int'(instr_q), int'(r.instr));
        check({tag, "_alu_en"},    alu_c,     r.exp_alu);
        check({tag, "_rf_we"},     rf_c,      r.exp_rf);
        check({tag, "_dmem_req"},  dreq_c,    r.exp_dreq);
        check({tag, "_dmem_we"},   dwe_c,     r.exp_dwe);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_hi, done_c;
        rec_t r;

        //          instr  iw  dw  z     drop  pc     lat alu rf dreq dwe
        tbl[0]  = '{8'h00, 0,  0, 1'b0, 1'b0, 8'h01, 4,  1,  1, 0,  0};  // R-ALU
        tbl[1]  = '{8'h21, 0,  0, 1'b0, 1'b0, 8'h02, 4,  1,  1, 0,  0};  // ADDI
        tbl[2]  = '{8'h40, 0,  3, 1'b0, 1'b0, 8'h03, 8,  1,  1, 4,  0};  // LW, 3 wait states
        tbl[3]  = '{8'h60, 1,  0, 1'b0, 1'b0, 8'h04, 4,  1,  0, 1,  1};  // SW
        tbl[4]  = '{8'h60, 0,  2, 1'b0, 1'b0, 8'h05, 6,  1,  0, 3,  3};  // SW, 2 wait states
        tbl[5]  = '{8'hA0, 0,  0, 1'b0, 1'b0, 8'h06, 2,  0,  0, 0,  0};  // reserved = NOP
        tbl[6]  = '{8'hDF, 0,  0, 1'b0, 1'b0, 8'h1F, 2,  0,  0, 0,  0};  // J -> 0x1F
        tbl[7]  = '{8'hC5, 0,  0, 1'b0, 1'b0, 8'h25, 2,  0,  0, 0,  0};  // J from 0x20 page -> 0x25
        tbl[8]  = '{8'h83, 0,  0, 1'b1, 1'b0, 8'h25, 3,  1,  0, 0,  0};  // BEQ -1 taken
        tbl[9]  = '{8'h83, 0,  0, 1'b0, 1'b0, 8'h26, 3,  1,  0, 0,  0};  // BEQ -1 not taken
        tbl[10] = '{8'h81, 0,  0, 1'b1, 1'b0, 8'h28, 3,  1,  0, 0,  0};  // BEQ +1 taken
        tbl[11] = '{8'h82, 2,  0, 1'b1, 1'b0, 8'h27, 3,  1,  0, 0,  0};  // BEQ -2 taken
        tbl[12] = '{8'h00, 15, 0, 1'b0, 1'b0, 8'h28, 4,  1,  1, 0,  0};  // ack exactly at timeout
        tbl[13] = '{8'hC0, 0,  0, 1'b0, 1'b0, 8'h20, 2,  0,  0, 0,  0};  // J -> 0x20
        tbl[14] = '{8'h21, 0,  0, 1'b1, 1'b0, 8'h21, 4,  1,  1, 0,  0};  // ADDI, zero ignored

        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = 8'h00;
        dmem_ack = 1'b0; zero_flag = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_pc",       int'(pc),         0);
        check("rst_instr_q",  int'(instr_q),    0);
        check("rst_imem_req", int'(imem_req),   0);
        check("rst_dmem_req", int'(dmem_req),   0);
        check("rst_strobes",  int'({alu_en, rf_we, instr_done}), 0);
        check("rst_flags",    int'({halted, fault}), 0);
        rst_n = 1'b1;

        // Ack with no request outstanding is ignored
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 8'hE0;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 8'h00;
        check("stray_ack_instr_q", int'(instr_q),  0);
        check("stray_ack_pc",      int'(pc),       0);
        check("idle_imem_req",     int'(imem_req), 0);

        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i], $sformatf("rec%0d", i));
        end
        check("table_no_fault", int'(fault), 0);

        // HALT is terminal: no further fetches, PC/IR frozen
        r = '{8'hE0, 0, 0, 1'b0, 1'b0, 8'h22, 2, 0, 0, 0, 0};
        run_instr(r, "halt");
        check("halt_flag", int'(halted), 1);
        req_hi = 0; done_c = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req) req_hi++;
            if (instr_done || alu_en || rf_we) done_c++;
        end
        check("halt_no_req",     req_hi,        0);
        check("halt_no_strobe",  done_c,        0);
        check("halt_pc_frozen",  int'(pc),      8'h22);
        check("halt_ir_frozen",  int'(instr_q), 8'hE0);

        do_reset();
        check("post_halt_rst_halted", int'(halted), 0);
        check("post_halt_rst_pc",     int'(pc),     0);

        // Fetch timeout: no ack for 16 request cycles
        run = 1'b1;
        req_hi = 0;
        while (imem_req !== 1'b1 && req_hi < 10) begin
            @(negedge clk);
            req_hi++;
        end
        check("to_req_seen", int'(imem_req), 1);
        repeat (15) @(negedge clk);
        check("to_no_early_fault", int'(fault),    0);
        check("to_req_held",       int'(imem_req), 1);
        @(negedge clk);
        check("to_fault",     int'(fault),    1);
        check("to_req_drop",  int'(imem_req), 0);
        req_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (imem_req) req_hi++;
        end
        imem_ack = 1'b1; imem_rdata = 8'h00;
        @(negedge clk);
        imem_ack = 1'b0;
        check("fault_no_req",    req_hi,         0);
        check("fault_pc_frozen", int'(pc),       0);
        check("fault_sticky",    int'(fault),    1);

        do_reset();
        check("post_fault_rst", int'(fault), 0);

        // run dropped during a store: store still retires, next fetch waits
        r = '{8'h60, 0, 2, 1'b0, 1'b1, 8'h01, 6, 1, 0, 3, 3};
        run_instr(r, "sw_run0");
        req_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) req_hi++;
        end
        check("run0_no_fetch", req_hi, 0);
        run = 1'b1;
        @(negedge clk);
        check("run1_fetch", int'(imem_req), 1);

        // Reset asserted in the middle of a load's data access
        imem_ack = 1'b1; imem_rdata = 8'h40;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 8'h00;
        req_hi = 0;
        while (dmem_req !== 1'b1 && req_hi < 10) begin
            @(negedge clk);
            req_hi++;
        end
        check("mem_req_seen", int'(dmem_req), 1);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check("midmem_rst_dmem_req", int'(dmem_req), 0);
        check("midmem_rst_pc",       int'(pc),       0);
        check("midmem_rst_instr_q",  int'(instr_q),  0);
        check("midmem_rst_strobes",  int'({alu_en, rf_we, instr_done, imem_req, dmem_we}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        done_c = 0;
        repeat (3) begin
            @(negedge clk);
            if (instr_done || rf_we || dmem_req || imem_req) done_c++;
        end
        dmem_ack = 1'b0;
        check("late_ack_ignored", done_c,   0);
        check("late_ack_pc",      int'(pc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
